// File: rtl/wb_matrix_job_master_if.sv
// Wishbone classic bus bundle between the job master and the accelerator.
interface wb_matrix_job_master_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i;
  logic [31:0] wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o,
    output wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o,
    input  wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_ack_i, wb_dat_i
  );
endinterface

// File: rtl/wb_matrix_job_master.sv
// Wishbone initiator running one matrix job on the accelerator:
// header, operands, GO, then read back each result word.
module wb_matrix_job_master #(
  parameter logic [31:0] BASE_ADDR    = 32'h3010_0000,
  parameter int          IN_MEM_SIZE  = 64,
  parameter int          OUT_MEM_SIZE = 16,
  parameter int          TIMEOUT      = 1024,
  parameter int          MAX_RETRY    = 15
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        job_start_i,
  input  logic [31:0] job_op_i,
  input  logic [15:0] job_wa_i,
  input  logic [15:0] job_ha_i,
  input  logic [15:0] job_wb_i,
  input  logic [15:0] job_hb_i,
  input  logic [31:0] op_data_i,
  input  logic        op_valid_i,
  output logic        op_ready_o,
  output logic [31:0] res_data_o,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic        job_busy_o,
  output logic        job_done_o,
  output logic        job_err_o,
  wb_matrix_job_master_if.master wb
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_WR_HDR, S_WR_OPS,
    S_WR_GO, S_RD_RES, S_PUSH, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [15:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] rty_q, rty_d;
  logic [31:0] op_q, op_d;
  logic [15:0] wa_q, wa_d, ha_q, ha_d;
  logic [15:0] wb_q, wb_d, hb_q, hb_d;
  logic [15:0] nops_q, nops_d;
  logic [15:0] nres_q, nres_d;
  logic [31:0] res_q, res_d;
  logic        rv_q, rv_d;
  logic        err_q, err_d;

  logic        ack, xfer;
  logic [31:0] word, wdat;
  logic [31:0] nops_w, nres_w;

  assign nops_w = 32'(wa_q) * 32'(ha_q)
                + 32'(wb_q) * 32'(hb_q);
  assign nres_w = 32'(ha_q) * 32'(wb_q);
  assign ack    = cyc_q & wb.wb_ack_i;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    rty_d   = rty_q;
    op_d    = op_q;
    wa_d    = wa_q;
    ha_d    = ha_q;
    wb_d    = wb_q;
    hb_d    = hb_q;
    nops_d  = nops_q;
    nres_d  = nres_q;
    res_d   = res_q;
    rv_d    = rv_q;
    err_d   = err_q;
    word    = '0;
    wdat    = '0;
    xfer    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (job_start_i) begin
          op_d    = job_op_i;
          wa_d    = job_wa_i;
          ha_d    = job_ha_i;
          wb_d    = job_wb_i;
          hb_d    = job_hb_i;
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (nops_w > 32'(IN_MEM_SIZE - 6) ||
            nres_w > 32'(OUT_MEM_SIZE) ||
            nres_w == 32'd0) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          nops_d  = nops_w[15:0];
          nres_d  = nres_w[15:0];
          idx_d   = '0;
          state_d = S_WR_HDR;
        end
      end
      S_WR_HDR: begin
        xfer = 1'b1;
        word = 32'(idx_q);
        unique case (idx_q)
          16'd0:   wdat = op_q;
          16'd1:   wdat = {16'b0, wa_q};
          16'd2:   wdat = {16'b0, ha_q};
          16'd3:   wdat = {16'b0, wb_q};
          default: wdat = {16'b0, hb_q};
        endcase
        if (ack) begin
          if (idx_q == 16'd4) begin
            idx_d   = '0;
            state_d = (nops_q == '0) ? S_WR_GO : S_WR_OPS;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end
      end
      S_WR_OPS: begin
        xfer = op_valid_i;
        word = 32'd6 + 32'(idx_q);
        wdat = op_data_i;
        if (ack) begin
          if (idx_q == nops_q - 16'd1) begin
            idx_d   = '0;
            state_d = S_WR_GO;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end
      end
      S_WR_GO: begin
        xfer = 1'b1;
        word = 32'd5;
        wdat = 32'hFFFF_FFFF;
        if (ack) begin
          idx_d   = '0;
          state_d = S_RD_RES;
        end
      end
      S_RD_RES: begin
        xfer = 1'b1;
        word = 32'(IN_MEM_SIZE) + 32'(idx_q);
        if (ack) begin
          res_d   = wb.wb_dat_i;
          rv_d    = 1'b1;
          state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        if (res_ready_i) begin
          rv_d = 1'b0;
          if (idx_q == nres_q - 16'd1) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 16'd1;
            state_d = S_RD_RES;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Idle bus cycle after any ack or timeout gives the slave its gap.
    if (xfer && !cyc_q) begin
      cyc_d = 1'b1;
      we_d  = (state_q != S_RD_RES);
      adr_d = BASE_ADDR + (word << 2);
      dat_d = (state_q != S_RD_RES) ? wdat : '0;
      tmo_d = '0;
    end else if (ack) begin
      cyc_d = 1'b0;
      tmo_d = '0;
      rty_d = '0;
    end else if (cyc_q) begin
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        cyc_d = 1'b0;
        tmo_d = '0;
        if (rty_q == RW'(MAX_RETRY)) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          rty_d = rty_q + RW'(1);
        end
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q <= S_IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      rty_q   <= '0;
      op_q    <= '0;
      wa_q    <= '0;
      ha_q    <= '0;
      wb_q    <= '0;
      hb_q    <= '0;
      nops_q  <= '0;
      nres_q  <= '0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      rty_q   <= rty_d;
      op_q    <= op_d;
      wa_q    <= wa_d;
      ha_q    <= ha_d;
      wb_q    <= wb_d;
      hb_q    <= hb_d;
      nops_q  <= nops_d;
      nres_q  <= nres_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
    end
  end

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = 4'hF;

  assign op_ready_o  = (state_q == S_WR_OPS) & ack;
  assign res_data_o  = res_q;
  assign res_valid_o = rv_q;
  assign job_err_o   = err_q;
  assign job_done_o  = (state_q == S_DONE);
  assign job_busy_o  = !(state_q inside {S_IDLE, S_DONE, S_ERR});

endmodule
